uart_hex_rx: RTL and testbench
==============================

Name: uart_hex_rx

Overview:
- Serial 8N1 UART receiver that turns ASCII hex text lines into 64-bit words.
- Host side of the debug channel: lets a host push 64-bit values (test vectors, memory patches, trigger values) into the core.
- Line format matches the debug trace dump: up to 16 hex digits, MSB nibble first, optional spaces, LF-terminated, e.g. "0000001A 12345678\n".
- Sits beside the debug trace logic, driven directly from the board RXD pin.

Parameters:
- BIT_CLKS, default `SERIAL_WCNT (config.vh): clocks per UART bit period; must be >= 4.
- MAX_DIGITS, default 16: hex digits accepted per line; fixed at 16 for a 64-bit payload.

Ports:
- CLK  input  1  system clock
- RST_X  input  1  reset, asynchronous, active-low
- w_rxd  input  1  raw serial input; idles high; asynchronous to CLK
- r_byte_valid  output  1  one-cycle pulse, a byte was received with a valid stop bit
- r_byte  output  8  last received byte; holds until the next byte
- r_valid  output  1  one-cycle pulse, a complete error-free line was parsed
- r_data  output  64  parsed value, right-aligned and zero-extended; holds until the next r_valid
- r_digits  output  5  number of digits in the line reported by r_valid (1..16)
- r_err  output  1  one-cycle pulse at the LF of a line containing any error
- r_busy  output  1  high while a frame is in progress (START..STOP)

Behaviour:
- Reset (asynchronous, RST_X low) forces the following; takes effect mid-frame as well, with no partial output afterwards:
  - Synchronizer flops = 1; FSM = IDLE.
  - All outputs 0; accumulator, digit count and line-error flag cleared.
- Synchronization: w_rxd passes through a 2-flop synchronizer; all logic uses the synchronized value (rxd_s).
- Receive FSM, 16-bit bit timer, 3-bit bit index:
  - IDLE: rxd_s == 0 -> START, timer = 0.
  - START: at timer == BIT_CLKS/2-1, sample rxd_s. If 1 -> IDLE (glitch, no output). If 0 -> DATA, index = 0, timer = 0.
  - DATA: sample every BIT_CLKS clocks (mid-bit), LSB first, into a shift register. After index 7 -> STOP.
  - STOP: sample after BIT_CLKS clocks.
    - Sample 1 -> r_byte updated, r_byte_valid pulses next cycle, FSM -> IDLE. IDLE re-arms immediately, so back-to-back frames with a single stop bit are received.
    - Sample 0 -> framing error: line-error flag set, no r_byte_valid, FSM -> BREAK.
  - BREAK: wait until rxd_s == 1, then -> IDLE.
  - r_busy = 1 in START, DATA and STOP.
- Parser, acting on each r_byte_valid byte:
  - '0'-'9', 'A'-'F', 'a'-'f':
    - If count < 16: acc <= {acc[59:0], nibble}, count++.
    - Otherwise set the line-error flag; acc unchanged.
  - 0x20 (space) and 0x0D (CR): ignored.
  - 0x0A (LF), evaluated in priority order:
    - Line-error flag set: r_err pulses one cycle.
    - Else count > 0: r_valid pulses one cycle, with r_data = acc and r_digits = count updated in the same cycle.
    - Else (count == 0, empty line): no output.
    - In all LF cases, acc, count and the error flag are cleared.
  - Any other byte: set the line-error flag.
- Latency:
  - r_byte_valid occurs 1 clock after the stop-bit sample.
  - r_valid / r_err occur 1 clock after the r_byte_valid of the LF.
  - r_valid and r_err are never high in the same cycle.
- A framing error during a byte stream poisons the current line only; the next line parses normally.

Test Plan:
- BIT_CLKS = 8 for all scenarios.
- Send "0000001A 12345678\n" -> exactly one r_valid, r_data = 64'h0000001A12345678, r_digits = 16, r_err never high.
- Send "ab\r\n" then "\n" -> one r_valid with r_data = 64'h00000000000000AB, r_digits = 2; the empty line produces no pulse.
- Send 17 '1' digits then LF, then "1\n" -> r_err pulse with no r_valid for the first line; the second line gives r_valid with r_data = 64'h1 and r_digits = 1.
- Send "12" then "G3\n" -> r_err pulse at the LF; r_data keeps its previous value.
- Send "5" with stop bit forced 0, hold line low 3 bit times, then "\n" and "77\n":
  - r_byte_valid stays low for the corrupted byte.
  - r_err pulses at the first LF.
  - "77\n" then gives r_data = 64'h77.
- Drive rxd low for 3 clocks only -> no r_byte_valid and r_busy returns to 0. Separately, assert RST_X mid-DATA -> all outputs 0 immediately, and the following "FF\n" gives r_data = 64'hFF.

Source files
------------

// File: rtl/uart_hex_rx.sv
// uart_hex_rx: 8N1 UART receiver feeding an ASCII hex line parser.
// Each LF-terminated line of up to MAX_DIGITS hex digits (spaces/CR ignored)
// is reported as a right-aligned 64-bit word, or flagged as an error line.

`ifndef SERIAL_WCNT
`define SERIAL_WCNT 16
`endif

module uart_hex_rx #(
    parameter int unsigned BIT_CLKS   = `SERIAL_WCNT,
    parameter int unsigned MAX_DIGITS = 16
) (
    input  logic        CLK,
    input  logic        RST_X,
    input  logic        w_rxd,
    output logic        r_byte_valid,
    output logic [7:0]  r_byte,
    output logic        r_valid,
    output logic [63:0] r_data,
    output logic [4:0]  r_digits,
    output logic        r_err,
    output logic        r_busy
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_BREAK = 3'd4;

    localparam logic [15:0] HALF_LAST = 16'(BIT_CLKS / 2 - 1);
    localparam logic [15:0] FULL_LAST = 16'(BIT_CLKS - 1);
    localparam logic [4:0]  DIG_MAX   = 5'(MAX_DIGITS);

    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_SP = 8'h20;

    logic        rxd_meta, rxd_s;
    logic [2:0]  state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        byte_done, frame_err;

    logic [63:0] acc_q, acc_d;
    logic [4:0]  count_q, count_d;
    logic        line_err_q, line_err_d;
    logic        valid_d, err_d;
    logic [63:0] data_d;
    logic [4:0]  digits_d;
    logic        is_hex;
    logic [3:0]  nibble;

    // Two-flop synchronizer; idles high so reset does not look like a start bit
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            rxd_meta <= 1'b1;
            rxd_s    <= 1'b1;
        end else begin
            rxd_meta <= w_rxd;
            rxd_s    <= rxd_meta;
        end
    end

    // Receive FSM next-state: mid-bit sampling off a free-running bit timer
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        byte_done = 1'b0;
        frame_err = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!rxd_s) begin
                    state_d = ST_START;
                    timer_d = '0;
                end
            end
            ST_START: begin
                if (timer_q == HALF_LAST) begin
                    timer_d = '0;
                    if (rxd_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DATA;
                        idx_d   = '0;
                    end
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            ST_DATA: begin
                if (timer_q == FULL_LAST) begin
                    timer_d = '0;
                    shift_d = {rxd_s, shift_q[7:1]};
                    if (idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            ST_STOP: begin
                if (timer_q == FULL_LAST) begin
                    timer_d = '0;
                    if (rxd_s) begin
                        byte_done = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        frame_err = 1'b1;
                        state_d   = ST_BREAK;
                    end
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            ST_BREAK: begin
                if (rxd_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Receive FSM state and byte output registers
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state_q      <= ST_IDLE;
            timer_q      <= '0;
            idx_q        <= '0;
            shift_q      <= '0;
            r_byte_valid <= 1'b0;
            r_byte       <= '0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            r_byte_valid <= byte_done;
            if (byte_done) begin
                r_byte <= shift_q;
            end
        end
    end

    assign r_busy = (state_q == ST_START) || (state_q == ST_DATA) || (state_q == ST_STOP);

    // ASCII hex digit decode of the last received byte
    always_comb begin
        is_hex = 1'b0;
        nibble = 4'h0;
        if (r_byte >= 8'h30 && r_byte <= 8'h39) begin
            is_hex = 1'b1;
            nibble = r_byte[3:0];
        end else if ((r_byte >= 8'h41 && r_byte <= 8'h46) ||
                     (r_byte >= 8'h61 && r_byte <= 8'h66)) begin
            is_hex = 1'b1;
            nibble = r_byte[3:0] + 4'd9;
        end
    end

    // Line parser next-state; a framing error only poisons the current line
    always_comb begin
        acc_d      = acc_q;
        count_d    = count_q;
        line_err_d = line_err_q | frame_err;
        valid_d    = 1'b0;
        err_d      = 1'b0;
        data_d     = r_data;
        digits_d   = r_digits;
        if (r_byte_valid) begin
            if (is_hex) begin
                if (count_q < DIG_MAX) begin
                    acc_d   = {acc_q[59:0], nibble};
                    count_d = count_q + 5'd1;
                end else begin
                    line_err_d = 1'b1;
                end
            end else if (r_byte == CH_LF) begin
                if (line_err_q) begin
                    err_d = 1'b1;
                end else if (count_q != 5'd0) begin
                    valid_d  = 1'b1;
                    data_d   = acc_q;
                    digits_d = count_q;
                end
                acc_d      = '0;
                count_d    = '0;
                line_err_d = frame_err;
            end else if (r_byte != CH_SP && r_byte != CH_CR) begin
                line_err_d = 1'b1;
            end
        end
    end

    // Line parser registers and line-level outputs
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            acc_q      <= '0;
            count_q    <= '0;
            line_err_q <= 1'b0;
            r_valid    <= 1'b0;
            r_err      <= 1'b0;
            r_data     <= '0;
            r_digits   <= '0;
        end else begin
            acc_q      <= acc_d;
            count_q    <= count_d;
            line_err_q <= line_err_d;
            r_valid    <= valid_d;
            r_err      <= err_d;
            r_data     <= data_d;
            r_digits   <= digits_d;
        end
    end

endmodule

// File: tb/tb_uart_hex_rx.sv
// Directed bench for uart_hex_rx with BIT_CLKS = 8.

module tb_uart_hex_rx;

    localparam int BIT = 8;

    logic        CLK;
    logic        RST_X;
    logic        w_rxd;
    logic        r_byte_valid;
    logic [7:0]  r_byte;
    logic        r_valid;
    logic [63:0] r_data;
    logic [4:0]  r_digits;
    logic        r_err;
    logic        r_busy;

    int tests = 0;
    int fails = 0;

    // Pulse counters, updated by the monitor only
    int n_bv    = 0;
    int n_valid = 0;
    int n_err   = 0;
    int n_both  = 0;

    int b_bv, b_valid, b_err;

    uart_hex_rx #(.BIT_CLKS(BIT), .MAX_DIGITS(16)) dut (
        .CLK          (CLK),
        .RST_X        (RST_X),
        .w_rxd        (w_rxd),
        .r_byte_valid (r_byte_valid),
        .r_byte       (r_byte),
        .r_valid      (r_valid),
        .r_data       (r_data),
        .r_digits     (r_digits),
        .r_err        (r_err),
        .r_busy       (r_busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (r_byte_valid) n_bv <= n_bv + 1;
        if (r_valid) n_valid <= n_valid + 1;
        if (r_err) n_err <= n_err + 1;
        if (r_valid && r_err) n_both <= n_both + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic v);
        w_rxd = v;
        repeat (BIT) @(negedge CLK);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
        w_rxd = 1'b1;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_frame(s[i], 1'b1);
    endtask

    task automatic mark();
        b_bv    = n_bv;
        b_valid = n_valid;
        b_err   = n_err;
    endtask

    // Let trailing pulses land, then sample away from the active edge
    task automatic settle();
        repeat (6) @(negedge CLK);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST_X = 1'b0;
        w_rxd = 1'b1;
        repeat (3) @(negedge CLK);
        check("rst_byte_valid", 64'(r_byte_valid), 64'd0);
        check("rst_byte", 64'(r_byte), 64'd0);
        check("rst_valid", 64'(r_valid), 64'd0);
        check("rst_data", r_data, 64'd0);
        check("rst_digits", 64'(r_digits), 64'd0);
        check("rst_busy", 64'(r_busy), 64'd0);
        RST_X = 1'b1;
        repeat (4) @(negedge CLK);

        // Full 16-digit line with a space
        mark();
        send_str("0000001A 12345678");
        send_frame(8'h0A, 1'b1);
        settle();
        check("l1_valid_cnt", 64'(n_valid - b_valid), 64'd1);
        check("l1_err_cnt", 64'(n_err - b_err), 64'd0);
        check("l1_data", r_data, 64'h0000001A12345678);
        check("l1_digits", 64'(r_digits), 64'd16);
        check("l1_bv_cnt", 64'(n_bv - b_bv), 64'd18);
        check("l1_last_byte", 64'(r_byte), 64'h0A);

        // Lower case with CR, then an empty line
        mark();
        send_str("ab");
        send_frame(8'h0D, 1'b1);
        send_frame(8'h0A, 1'b1);
        settle();
        check("l2_valid_cnt", 64'(n_valid - b_valid), 64'd1);
        check("l2_data", r_data, 64'h00000000000000AB);
        check("l2_digits", 64'(r_digits), 64'd2);
        mark();
        send_frame(8'h0A, 1'b1);
        settle();
        check("empty_valid_cnt", 64'(n_valid - b_valid), 64'd0);
        check("empty_err_cnt", 64'(n_err - b_err), 64'd0);

        // 17 digits overflow, then a one-digit line
        mark();
        send_str("11111111111111111");
        send_frame(8'h0A, 1'b1);
        settle();
        check("ovf_err_cnt", 64'(n_err - b_err), 64'd1);
        check("ovf_valid_cnt", 64'(n_valid - b_valid), 64'd0);
        check("ovf_data_hold", r_data, 64'h00000000000000AB);
        mark();
        send_str("1");
        send_frame(8'h0A, 1'b1);
        settle();
        check("one_valid_cnt", 64'(n_valid - b_valid), 64'd1);
        check("one_data", r_data, 64'h1);
        check("one_digits", 64'(r_digits), 64'd1);

        // Illegal character
        mark();
        send_str("12");
        send_str("G3");
        send_frame(8'h0A, 1'b1);
        settle();
        check("bad_err_cnt", 64'(n_err - b_err), 64'd1);
        check("bad_valid_cnt", 64'(n_valid - b_valid), 64'd0);
        check("bad_data_hold", r_data, 64'h1);

        // Framing error, line held low 3 bit times
        mark();
        send_frame(8'h35, 1'b0);
        w_rxd = 1'b0;
        repeat (3 * BIT) @(negedge CLK);
        w_rxd = 1'b1;
        repeat (2 * BIT) @(negedge CLK);
        check("frm_bv_cnt", 64'(n_bv - b_bv), 64'd0);
        send_frame(8'h0A, 1'b1);
        settle();
        check("frm_err_cnt", 64'(n_err - b_err), 64'd1);
        check("frm_valid_cnt", 64'(n_valid - b_valid), 64'd0);
        mark();
        send_str("77");
        send_frame(8'h0A, 1'b1);
        settle();
        check("frm_next_valid", 64'(n_valid - b_valid), 64'd1);
        check("frm_next_data", r_data, 64'h77);

        // Short glitch is rejected
        mark();
        w_rxd = 1'b0;
        repeat (3) @(negedge CLK);
        w_rxd = 1'b1;
        repeat (20) @(negedge CLK);
        settle();
        check("glitch_bv_cnt", 64'(n_bv - b_bv), 64'd0);
        check("glitch_busy", 64'(r_busy), 64'd0);

        // Reset in the middle of the data bits
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        check("mid_busy", 64'(r_busy), 64'd1);
        RST_X = 1'b0;
        #1;
        check("mid_rst_busy", 64'(r_busy), 64'd0);
        check("mid_rst_data", r_data, 64'd0);
        check("mid_rst_byte", 64'(r_byte), 64'd0);
        check("mid_rst_digits", 64'(r_digits), 64'd0);
        w_rxd = 1'b1;
        repeat (4) @(negedge CLK);
        RST_X = 1'b1;
        repeat (4) @(negedge CLK);
        mark();
        send_str("FF");
        send_frame(8'h0A, 1'b1);
        settle();
        check("post_rst_valid", 64'(n_valid - b_valid), 64'd1);
        check("post_rst_data", r_data, 64'hFF);
        check("post_rst_digits", 64'(r_digits), 64'd2);

        check("never_both", 64'(n_both), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
